instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
Parametrised, synchronous, run-time-loadable instruction memory for the pipelined CPU fetch stage. Replaces fixed per-address program contents with a load port, a one-cycle registered fetch with stall hold, a NOP default for unwritten or out-of-range words, and sticky HALT detection. Sits between the PC/fetch logic and the IF/ID register; a bench or boot loader fills it before the core runs.

Parameters:
ADDR_WIDTH, 5, word-address width (byte offsets are not used)
DEPTH, 32, number of implemented words; must be <= 2**ADDR_WIDTH
DATA_WIDTH, 32, instruction width
NOP_WORD, 32'h0000_0013, word returned for unwritten or out-of-range addresses (addi x0,x0,0)
HALT_WORD, 32'hFFFF_FFFF, word that halts fetch

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
load_we  in  1  write strobe; honoured only in LOAD state
load_addr  in  ADDR_WIDTH  word address to write
load_data  in  DATA_WIDTH  word to write
run_start  in  1  single-cycle pulse: LOAD -> RUN
reload  in  1  single-cycle pulse: RUN/HALTED -> LOAD
fetch_req  in  1  fetch request; honoured only in RUN
fetch_addr  in  ADDR_WIDTH  word address to fetch
stall  in  1  hold current output (pipeline back-pressure)
instr  out  DATA_WIDTH  fetched instruction
instr_addr  out  ADDR_WIDTH  address of the word on instr
instr_valid  out  1  instr/instr_addr are a fetch result
halted  out  1  sticky: HALT_WORD has been fetched
loading  out  1  high while in LOAD state

Behaviour:
- States: LOAD, RUN, HALTED. Reset: state=LOAD, instr=NOP_WORD, instr_addr=0, instr_valid=0, halted=0, all per-word written bits cleared. Memory array itself is not reset.
- Per-word written bit: a fetch of a word whose bit is clear returns NOP_WORD. A fetch with fetch_addr >= DEPTH returns NOP_WORD. A load with load_addr >= DEPTH is dropped.
- LOAD: load_we writes mem[load_addr] and sets its written bit at the edge. Rewriting the same address overwrites it. fetch_req is ignored and instr_valid=0. run_start moves to RUN. A load_we in the same cycle as run_start is committed.
- RUN, stall=0, fetch_req=1: 1-cycle latency. At the next edge: instr=word, instr_addr=fetch_addr, instr_valid=1. A word loaded in the cycle before (same cycle as run_start) is visible.
- RUN, stall=0, fetch_req=0: next cycle instr_valid=0 and instr=NOP_WORD.
- stall=1 (any state except reset): instr, instr_addr and instr_valid hold. The fetch_req in that cycle is dropped; the fetch unit re-presents it.
- HALT: when the fetched word equals HALT_WORD, it is output with instr_valid=1, halted=1 in the same cycle, and state goes to HALTED. In HALTED, fetch_req is ignored. The output holds while stall=1; otherwise instr_valid drops to 0 the next cycle. halted stays 1.
- load_we outside LOAD is ignored, and memory is unchanged.
- reload from RUN or HALTED: state=LOAD, halted=0, instr_valid=0 next cycle. Memory and written bits are kept. reload beats fetch_req and stall in the same cycle. reload in LOAD and run_start outside LOAD are ignored.
- rst overrides everything, including mid-load and mid-stall.
- loading is derived from the state register, so it is 1 in the cycle after reset.

Test Plan:
- Load factorial: addr0=0050_0513, addr1=00c0_00ef, addr3=FFFF_FFFF, then run_start. Fetch 0 -> next cycle instr=0050_0513, instr_addr=0, valid=1. Fetch 1 -> 00c0_00ef.
- Unwritten/out-of-range: after the load above, fetch 2 -> 0000_0013 valid. With DEPTH=24, load_we at addr 30 is dropped; fetch 30 -> 0000_0013.
- HALT: fetch 3 -> instr=FFFF_FFFF, valid=1, halted=1. Next cycle valid=0. A later fetch 0 is ignored and halted stays 1.
- Stall: fetch 0, then stall=1 for 3 cycles with fetch_req=1, fetch_addr=1 -> instr holds 0050_0513 and valid=1 throughout. Release stall -> the next fetch 1 returns 00c0_00ef.
- Reload/reset: after halt, pulse reload -> loading=1, halted=0. Write addr3=0000_0013, run_start, fetch 0 -> still 0050_0513, fetch 3 -> 0000_0013 with no halt. Then rst -> fetch 0 after run_start returns 0000_0013.
- Gating: load_we in RUN to addr0 with 1234_5678 -> fetch 0 still 0050_0513. fetch_req in LOAD -> instr_valid stays 0.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory for the fetch stage: load port, one-cycle
// registered fetch with stall hold, NOP for unwritten/out-of-range words, sticky HALT.
module instr_mem_loadable #(
   parameter int unsigned           ADDR_WIDTH = 5,
   parameter int unsigned           DEPTH      = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0013,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_we,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  run_start,
   input  logic                  reload,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   input  logic                  stall,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   output logic                  instr_valid,
   output logic                  halted,
   output logic                  loading
);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t                state_r;
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0]      written_r;
   logic                  load_ok_s;
   logic [DATA_WIDTH-1:0] fetch_word_s;

   function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
      return (32'(a) < DEPTH);
   endfunction

   // Qualify a load: LOAD state only, in-range address, never while reset is asserted
   always_comb begin
      load_ok_s = 1'b0;
      if (!rst && (state_r == ST_LOAD) && load_we && addr_in_range(load_addr)) begin
         load_ok_s = 1'b1;
      end else begin
         load_ok_s = 1'b0;
      end
   end

   // Word presented to the fetch register; unwritten or out-of-range reads give NOP
   always_comb begin
      fetch_word_s = NOP_WORD;
      if (addr_in_range(fetch_addr)) begin
         if (written_r[fetch_addr]) begin
            fetch_word_s = mem_r[fetch_addr];
         end else begin
            fetch_word_s = NOP_WORD;
         end
      end else begin
         fetch_word_s = NOP_WORD;
      end
   end

   // Storage array; contents survive reset, validity is tracked by written_r
   always_ff @(posedge clk) begin
      if (load_ok_s) begin
         mem_r[load_addr] <= load_data;
      end
   end

   // Per-word written bits, cleared by reset, kept across reload
   always_ff @(posedge clk) begin
      if (rst) begin
         written_r <= {DEPTH{1'b0}};
      end else if (load_ok_s) begin
         written_r[load_addr] <= 1'b1;
      end
   end

   // Mode FSM with registered fetch outputs; reload wins over stall and fetch_req
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_LOAD;
         instr       <= NOP_WORD;
         instr_addr  <= {ADDR_WIDTH{1'b0}};
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state_r)
            ST_LOAD: begin
               if (run_start) begin
                  state_r <= ST_RUN;
               end
               if (!stall) begin
                  instr       <= NOP_WORD;
                  instr_valid <= 1'b0;
               end
            end
            ST_RUN: begin
               if (reload) begin
                  state_r     <= ST_LOAD;
                  instr       <= NOP_WORD;
                  instr_valid <= 1'b0;
                  halted      <= 1'b0;
               end else if (!stall) begin
                  if (fetch_req) begin
                     instr       <= fetch_word_s;
                     instr_addr  <= fetch_addr;
                     instr_valid <= 1'b1;
                     if (fetch_word_s == HALT_WORD) begin
                        halted  <= 1'b1;
                        state_r <= ST_HALTED;
                     end
                  end else begin
                     instr       <= NOP_WORD;
                     instr_valid <= 1'b0;
                  end
               end
            end
            ST_HALTED: begin
               if (reload) begin
                  state_r     <= ST_LOAD;
                  instr       <= NOP_WORD;
                  instr_valid <= 1'b0;
                  halted      <= 1'b0;
               end else if (!stall) begin
                  instr       <= NOP_WORD;
                  instr_valid <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_LOAD;
               instr       <= NOP_WORD;
               instr_valid <= 1'b0;
               halted      <= 1'b0;
            end
         endcase
      end
   end

   assign loading = (state_r == ST_LOAD);

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: directed program flow plus random
// stimulus against a cycle-level reference model of the memory and its modes.
module tb_instr_mem_loadable;
   localparam int          AW    = 5;
   localparam int          DEPTH = 24;
   localparam int          DW    = 32;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          rst, load_we, run_start, reload, fetch_req, stall;
   logic [AW-1:0] load_addr, fetch_addr;
   logic [DW-1:0] load_data;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_addr;
   logic          instr_valid, halted, loading;

   always #5 clk = ~clk;

   instr_mem_loadable #(
      .ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW),
      .NOP_WORD(NOP), .HALT_WORD(HALT)
   ) dut (
      .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .run_start(run_start), .reload(reload),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
      .instr(instr), .instr_addr(instr_addr), .instr_valid(instr_valid),
      .halted(halted), .loading(loading)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: program image, written flags, mode and expected outputs
   logic [31:0] m_mem [32];
   bit          m_wr  [32];
   bit          m_loading, m_halted;
   bit          e_valid, e_instr_known;
   logic [31:0] e_instr;
   logic [4:0]  e_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [4:0] a);
      if (int'(a) < DEPTH && m_wr[a]) return m_mem[a];
      return NOP;
   endfunction

   task automatic model_step();
      logic [31:0] w;
      if (rst) begin
         m_loading = 1'b1; m_halted = 1'b0;
         e_valid = 1'b0; e_instr = NOP; e_addr = 5'd0; e_instr_known = 1'b1;
         for (int i = 0; i < 32; i++) m_wr[i] = 1'b0;
      end else if (m_loading) begin
         if (load_we && int'(load_addr) < DEPTH) begin
            m_mem[load_addr] = load_data;
            m_wr[load_addr]  = 1'b1;
         end
         if (!stall) begin
            e_valid = 1'b0; e_instr_known = 1'b0;
         end
         if (run_start) m_loading = 1'b0;
      end else if (reload) begin
         m_loading = 1'b1; m_halted = 1'b0;
         e_valid = 1'b0; e_instr_known = 1'b0;
      end else if (!stall) begin
         if (m_halted) begin
            e_valid = 1'b0; e_instr_known = 1'b0;
         end else if (fetch_req) begin
            w = ref_word(fetch_addr);
            e_instr = w; e_addr = fetch_addr; e_valid = 1'b1; e_instr_known = 1'b1;
            if (w == HALT) m_halted = 1'b1;
         end else begin
            e_instr = NOP; e_valid = 1'b0; e_instr_known = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("valid", 32'(instr_valid), 32'(e_valid));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("loading", 32'(loading), 32'(m_loading));
      if (e_instr_known) chk("instr", instr, e_instr);
      if (e_valid) chk("instr_addr", 32'(instr_addr), 32'(e_addr));
   endtask

   task automatic idle();
      rst = 1'b0; load_we = 1'b0; run_start = 1'b0; reload = 1'b0;
      fetch_req = 1'b0; stall = 1'b0;
   endtask

   task automatic do_load(input logic [4:0] a, input logic [31:0] d);
      load_we = 1'b1; load_addr = a; load_data = d;
      tick();
      load_we = 1'b0;
   endtask

   task automatic do_fetch(input logic [4:0] a);
      fetch_req = 1'b1; fetch_addr = a;
      tick();
      fetch_req = 1'b0;
   endtask

   initial begin
      idle();
      load_addr = 5'd0; load_data = 32'h0; fetch_addr = 5'd0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_instr", instr, NOP);
      chk("rst_addr", 32'(instr_addr), 32'h0);
      chk("rst_loading", 32'(loading), 32'h1);
      rst = 1'b0;

      // fetch_req ignored while loading
      do_fetch(5'd0);
      chk("load_fetch_gated", 32'(instr_valid), 32'h0);

      do_load(5'd0, 32'h0050_0513);
      do_load(5'd30, 32'hDEAD_BEEF);
      do_load(5'd1, 32'h1111_1111);
      do_load(5'd1, 32'h00c0_00ef);
      load_we = 1'b1; load_addr = 5'd3; load_data = HALT; run_start = 1'b1;
      tick();
      idle();
      chk("run_entered", 32'(loading), 32'h0);

      do_fetch(5'd0);
      chk("fact0", instr, 32'h0050_0513);
      chk("fact0_addr", 32'(instr_addr), 32'h0);
      do_fetch(5'd1);
      chk("fact1_overwrite", instr, 32'h00c0_00ef);
      do_fetch(5'd2);
      chk("unwritten_nop", instr, NOP);
      chk("unwritten_valid", 32'(instr_valid), 32'h1);
      do_fetch(5'd30);
      chk("oor_nop", instr, NOP);
      chk("oor_addr", 32'(instr_addr), 32'd30);

      // load in RUN is ignored; idle cycle drops valid
      load_we = 1'b1; load_addr = 5'd0; load_data = 32'h1234_5678;
      tick();
      load_we = 1'b0;
      chk("idle_nop", instr, NOP);
      chk("idle_invalid", 32'(instr_valid), 32'h0);
      do_fetch(5'd0);
      chk("run_load_gated", instr, 32'h0050_0513);

      // stall holds output and drops the presented fetch
      stall = 1'b1; fetch_req = 1'b1; fetch_addr = 5'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold", instr, 32'h0050_0513);
         chk("stall_valid", 32'(instr_valid), 32'h1);
      end
      stall = 1'b0;
      tick();
      fetch_req = 1'b0;
      chk("stall_release", instr, 32'h00c0_00ef);

      // halt
      do_fetch(5'd3);
      chk("halt_word", instr, HALT);
      chk("halt_flag", 32'(halted), 32'h1);
      stall = 1'b1;
      tick();
      stall = 1'b0;
      chk("halt_stall_hold", 32'(instr_valid), 32'h1);
      tick();
      chk("halt_drop", 32'(instr_valid), 32'h0);
      do_fetch(5'd0);
      chk("halted_fetch_gated", 32'(instr_valid), 32'h0);
      chk("halted_sticky", 32'(halted), 32'h1);

      // reload keeps memory
      reload = 1'b1;
      tick();
      reload = 1'b0;
      chk("reload_loading", 32'(loading), 32'h1);
      chk("reload_halt_clr", 32'(halted), 32'h0);
      do_load(5'd3, NOP);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      do_fetch(5'd0);
      chk("reload_kept", instr, 32'h0050_0513);
      do_fetch(5'd3);
      chk("reload_new3", instr, NOP);
      chk("reload_nohalt", 32'(halted), 32'h0);

      // reload beats stall
      do_fetch(5'd1);
      reload = 1'b1; stall = 1'b1; fetch_req = 1'b1; fetch_addr = 5'd0;
      tick();
      idle();
      chk("reload_vs_stall", 32'(instr_valid), 32'h0);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;

      // reset mid-stall clears written bits
      do_fetch(5'd1);
      rst = 1'b1; stall = 1'b1; fetch_req = 1'b1; fetch_addr = 5'd0;
      tick();
      idle();
      chk("rst_stall_valid", 32'(instr_valid), 32'h0);
      chk("rst_stall_instr", instr, NOP);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      do_fetch(5'd0);
      chk("rst_cleared", instr, NOP);

      // random phase
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         load_we    = 1'($urandom_range(0, 1));
         load_addr  = 5'($urandom_range(0, 31));
         load_data  = ($urandom_range(0, 7) == 0) ? HALT : $urandom();
         run_start  = ($urandom_range(0, 9) == 0);
         reload     = ($urandom_range(0, 39) == 0);
         fetch_req  = ($urandom_range(0, 9) < 7);
         fetch_addr = 5'($urandom_range(0, 31));
         stall      = ($urandom_range(0, 3) == 0);
         tick();
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
